spike_output_drain: RTL
=======================

Name: spike_output_drain

Overview:
- Host-side consumer of the Output Queue: the reading end of the queue that the system controller and internal router fill.
- Pops each output spike entry (BT plus neuron ID) exactly once and forwards it to the host as a valid/ready stream word.
- Inserts an end-of-step marker word carrying the spike count for each completed biological timestep.
- Sits between the Output Queue and the host interface; replaces raw external dequeue pulsing.

Parameters:
- BT_WIDTH, 36, biological time width; matches queue BT field.
- NEURON_ADDR_WIDTH, 8, neuron ID width.
- TOTAL_WIDTH, 32, width of the running sent-event counter.

Ports:
- Clock  in  1  system clock
- Reset  in  1  synchronous, active-high
- Enable  in  1  drain permitted; sampled in IDLE only
- CurrentBT  in  BT_WIDTH  controller's current biological time
- IsOutQueueEmpty  in  1  Output Queue empty flag
- OutBT_Head  in  BT_WIDTH  BT of queue head
- OutNID_Head  in  NEURON_ADDR_WIDTH  neuron ID of queue head
- OutDequeue  out  1  registered single-cycle pop strobe
- HostValid  out  1  HostData valid
- HostReady  in  1  host accepts word
- HostData  out  1+BT_WIDTH+NEURON_ADDR_WIDTH+1  {Type, BT, Payload}
- EventsSent  out  TOTAL_WIDTH  running count of event words accepted
- Busy  out  1  state != IDLE

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - LastBT=0, StepCount=0, HaveStep=0.
  - Reset dominates everything, including mid-handshake; no pop issued in the reset cycle.
- Queue contract: the head is valid whenever IsOutQueueEmpty=0. The head updates one cycle after the OutDequeue pulse.
- States: IDLE, POP, SETTLE, SEND_EVT, SEND_MARK.
- IDLE transitions, first match wins:
  - (a) HaveStep && ~IsOutQueueEmpty && OutBT_Head!=LastBT -> SEND_MARK. A step boundary is seen in the queue.
  - (b) HaveStep && IsOutQueueEmpty && CurrentBT!=LastBT -> SEND_MARK. The controller has advanced past LastBT.
  - (c) Enable && ~IsOutQueueEmpty -> capture OutBT_Head and OutNID_Head into holding registers, then go to POP.
  - Otherwise stay in IDLE.
  - Markers (a) and (b) are flushed even when Enable=0, so step accounting closes.
- POP: OutDequeue=1 for exactly this cycle -> SETTLE.
- SETTLE: OutDequeue=0; wait one cycle for the queue head to update -> SEND_EVT.
- SEND_EVT:
  - HostValid=1; HostData={1'b0, heldBT, 1'b0, heldNID}.
  - On HostReady: LastBT<=heldBT; HaveStep<=1; StepCount<=StepCount+1, saturating at all-ones (2^(NEURON_ADDR_WIDTH+1)-1); EventsSent<=EventsSent+1, wrapping. Then -> IDLE.
- SEND_MARK:
  - HostValid=1; HostData={1'b1, LastBT, StepCount}.
  - On HostReady: StepCount<=0; HaveStep<=0 (LastBT retained) -> IDLE.
- Handshake rules:
  - HostData is stable while HostValid=1 and HostReady=0.
  - HostValid is never withdrawn before acceptance, even if Enable falls.
  - HostReady while HostValid=0 is ignored.
- Latency: non-empty seen in IDLE at cycle t -> OutDequeue at t+1 -> HostValid at t+3. Minimum 4 cycles per event with HostReady held high.
- Pop safety:
  - OutDequeue is never asserted while the captured entry is unsent.
  - OutDequeue is never asserted without a non-empty sample in the preceding IDLE cycle.
  - Exactly one pop per entry.
- No marker is emitted for a timestep with zero spikes.
- Out-of-order BT is not checked; any BT change closes the step.

Decomposition:
- Shared package spike_io_pkg holds:
  - state encoding constants;
  - TYPE_EVENT=0 and TYPE_MARK=1;
  - HostData field offset and width constants derived from the parameters.
- Sub-module host_word_reg: single-entry valid/ready holding register used by both send states. One FSM remains in the top module.

Test Plan:
- Single event: queue holds BT=3, NID=17; HostReady=1 -> OutDequeue pulses once at t+1; HostData={0,3,17} at t+3; EventsSent=1; no marker while CurrentBT=3.
- Step boundary: queue holds {BT5,N1}, {BT5,N2}, {BT6,N9} -> two events, then marker {1,5,2}, then event {0,6,9}; exactly 3 OutDequeue pulses.
- Empty-queue flush: after the last BT=7 event is sent, queue empty, CurrentBT goes 7→8 -> marker {1,7,1} follows; with Enable=0 the marker is still emitted.
- Backpressure: HostReady=0 for 10 cycles during SEND_EVT -> HostData stable, no further OutDequeue, accepted exactly once when HostReady=1.
- Saturation: 600 events at BT=2 with NEURON_ADDR_WIDTH=8 -> marker payload 511; EventsSent=600.
- Reset mid-operation: assert Reset in SEND_MARK -> next cycle all outputs 0, state IDLE, StepCount=0; queue entries not yet popped are then drained normally.

Source files
------------

// File: rtl/spike_io_pkg.sv
// spike_io_pkg
//   Shared definitions for the host-side output-queue drain: FSM state
//   encoding, host word type codes, default widths and helpers that derive
//   the host word field layout from the width parameters.
//   Host word layout (MSB..LSB): {Type, BT, Payload}
//     Event  payload = {1'b0, neuron ID}
//     Marker payload = spike count for the closed step
package spike_io_pkg;

   localparam int BT_WIDTH_DEF          = 36;
   localparam int NEURON_ADDR_WIDTH_DEF = 8;
   localparam int TOTAL_WIDTH_DEF       = 32;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_POP       = 3'd1,
      ST_SETTLE    = 3'd2,
      ST_SEND_EVT  = 3'd3,
      ST_SEND_MARK = 3'd4
   } drain_state_e;

   localparam logic TYPE_EVENT = 1'b0;
   localparam logic TYPE_MARK  = 1'b1;

   function automatic int payload_width(input int naw);
      return naw + 1;
   endfunction

   function automatic int host_width(input int btw, input int naw);
      return 1 + btw + payload_width(naw);
   endfunction

   function automatic int bt_lsb(input int naw);
      return payload_width(naw);
   endfunction

   function automatic int type_bit(input int btw, input int naw);
      return btw + payload_width(naw);
   endfunction

   localparam int PAYLOAD_W_DEF = payload_width(NEURON_ADDR_WIDTH_DEF);
   localparam int HOST_W_DEF    = host_width(BT_WIDTH_DEF, NEURON_ADDR_WIDTH_DEF);
   localparam int BT_LSB_DEF    = bt_lsb(NEURON_ADDR_WIDTH_DEF);
   localparam int TYPE_BIT_DEF  = type_bit(BT_WIDTH_DEF, NEURON_ADDR_WIDTH_DEF);

endpackage

// File: rtl/spike_output_drain_host_word_reg.sv
// host_word_reg
//   Single-entry valid/ready holding register for the host stream. A word
//   is loaded once and held unchanged until the host accepts it.
// Ports:
//   Clock, Reset  clock, synchronous active-high reset
//   load_i        load data_i and raise valid (only issued while empty)
//   data_i        word to load
//   ready_i       host accepts the held word
//   valid_o       held word valid
//   data_o        held word
//   fire_o        handshake completes this cycle
module host_word_reg
   import spike_io_pkg::*;
#(
   parameter int W = HOST_W_DEF
) (
   input  logic         Clock,
   input  logic         Reset,
   input  logic         load_i,
   input  logic [W-1:0] data_i,
   input  logic         ready_i,
   output logic         valid_o,
   output logic [W-1:0] data_o,
   output logic         fire_o
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;

   assign fire_o  = valid_q & ready_i;
   assign valid_o = valid_q;
   assign data_o  = data_q;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end else if (fire_o) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: rtl/spike_output_drain.sv
// spike_output_drain
//   Drains the Output Queue toward the host: each entry is popped exactly
//   once and sent as an event word; a marker word carrying the spike count
//   closes every timestep that produced at least one spike.
// Ports:
//   Clock, Reset      clock, synchronous active-high reset
//   Enable            drain permitted (sampled in IDLE only)
//   CurrentBT         controller's current biological time
//   IsOutQueueEmpty   queue empty flag
//   OutBT_Head/OutNID_Head  queue head entry
//   OutDequeue        registered single-cycle pop strobe
//   HostValid/HostReady/HostData  host stream {Type, BT, Payload}
//   EventsSent        running count of accepted event words (wraps)
//   Busy              FSM not in IDLE
//
//   state      | meaning
//   -----------+------------------------------------------------------
//   IDLE       | decide: flush a marker, pop the head, or wait
//   POP        | OutDequeue high for this one cycle
//   SETTLE     | let the queue head advance; load the event word
//   SEND_EVT   | event word offered until accepted
//   SEND_MARK  | end-of-step marker offered until accepted
module spike_output_drain
   import spike_io_pkg::*;
#(
   parameter int BT_WIDTH          = BT_WIDTH_DEF,
   parameter int NEURON_ADDR_WIDTH = NEURON_ADDR_WIDTH_DEF,
   parameter int TOTAL_WIDTH       = TOTAL_WIDTH_DEF
) (
   input  logic                                  Clock,
   input  logic                                  Reset,
   input  logic                                  Enable,
   input  logic [BT_WIDTH-1:0]                   CurrentBT,
   input  logic                                  IsOutQueueEmpty,
   input  logic [BT_WIDTH-1:0]                   OutBT_Head,
   input  logic [NEURON_ADDR_WIDTH-1:0]          OutNID_Head,
   output logic                                  OutDequeue,
   output logic                                  HostValid,
   input  logic                                  HostReady,
   output logic [BT_WIDTH+NEURON_ADDR_WIDTH+1:0] HostData,
   output logic [TOTAL_WIDTH-1:0]                EventsSent,
   output logic                                  Busy
);

   localparam int PW = payload_width(NEURON_ADDR_WIDTH);
   localparam int HW = host_width(BT_WIDTH, NEURON_ADDR_WIDTH);

   drain_state_e                 state_q, state_d;
   logic [BT_WIDTH-1:0]          last_bt_q, last_bt_d;
   logic [PW-1:0]                step_cnt_q, step_cnt_d;
   logic                         have_step_q, have_step_d;
   logic [BT_WIDTH-1:0]          held_bt_q, held_bt_d;
   logic [NEURON_ADDR_WIDTH-1:0] held_nid_q, held_nid_d;
   logic [TOTAL_WIDTH-1:0]       events_q, events_d;
   logic                         deq_q, deq_d;

   logic          word_load;
   logic [HW-1:0] word_data;
   logic          word_fire;
   logic          step_closed;

   // A step closes when the queue head moves to a new BT, or when the queue
   // is empty and the controller has moved on; either way only if the step
   // actually carried spikes.
   assign step_closed = have_step_q &&
                        (IsOutQueueEmpty ? (CurrentBT != last_bt_q)
                                         : (OutBT_Head != last_bt_q));

   always_comb begin
      state_d     = state_q;
      last_bt_d   = last_bt_q;
      step_cnt_d  = step_cnt_q;
      have_step_d = have_step_q;
      held_bt_d   = held_bt_q;
      held_nid_d  = held_nid_q;
      events_d    = events_q;
      word_load   = 1'b0;
      word_data   = '0;
      case (state_q)
         ST_IDLE: begin
            if (step_closed) begin
               state_d   = ST_SEND_MARK;
               word_load = 1'b1;
               word_data = {TYPE_MARK, last_bt_q, step_cnt_q};
            end else if (Enable && !IsOutQueueEmpty) begin
               held_bt_d  = OutBT_Head;
               held_nid_d = OutNID_Head;
               state_d    = ST_POP;
            end
         end
         ST_POP:    state_d = ST_SETTLE;
         ST_SETTLE: begin
            state_d   = ST_SEND_EVT;
            word_load = 1'b1;
            word_data = {TYPE_EVENT, held_bt_q, 1'b0, held_nid_q};
         end
         ST_SEND_EVT: begin
            if (word_fire) begin
               last_bt_d   = held_bt_q;
               have_step_d = 1'b1;
               if (step_cnt_q != '1) step_cnt_d = step_cnt_q + 1'b1;
               events_d    = events_q + 1'b1;
               state_d     = ST_IDLE;
            end
         end
         ST_SEND_MARK: begin
            if (word_fire) begin
               step_cnt_d  = '0;
               have_step_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      deq_d = (state_d == ST_POP);
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q     <= ST_IDLE;
         last_bt_q   <= '0;
         step_cnt_q  <= '0;
         have_step_q <= 1'b0;
         held_bt_q   <= '0;
         held_nid_q  <= '0;
         events_q    <= '0;
         deq_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_bt_q   <= last_bt_d;
         step_cnt_q  <= step_cnt_d;
         have_step_q <= have_step_d;
         held_bt_q   <= held_bt_d;
         held_nid_q  <= held_nid_d;
         events_q    <= events_d;
         deq_q       <= deq_d;
      end
   end

   host_word_reg #(.W(HW)) u_word (
      .Clock   (Clock),
      .Reset   (Reset),
      .load_i  (word_load),
      .data_i  (word_data),
      .ready_i (HostReady),
      .valid_o (HostValid),
      .data_o  (HostData),
      .fire_o  (word_fire)
   );

   assign OutDequeue = deq_q;
   assign EventsSent = events_q;
   assign Busy       = (state_q != ST_IDLE);

endmodule
